// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage owning the PC and the IF/ID pipeline register
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_SIZE  = 96,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_pc_plus4_o,
  output logic [31:0] if_instr_o,
  output logic        if_valid_o,
  output logic        halted_o,
  output logic        misalign_o,
  output logic [31:0] fetch_count_o
);
  localparam logic [31:0] LIMIT = 32'(MEM_SIZE * 4);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, id_pc_q, id_pc_d, id_instr_q, id_instr_d, count_q, count_d;
  logic        id_valid_q, id_valid_d, mis_q, mis_d;
  logic [31:0] target;
  logic        in_range, target_in, target_mis;
  assign target        = {redirect_pc_i[31:2], 2'b00};
  assign target_mis    = |redirect_pc_i[1:0];
  assign in_range      = pc_q < LIMIT;
  assign target_in     = target < LIMIT;
  assign imem_addr_o   = pc_q;
  assign if_pc_o       = id_pc_q;
  assign if_pc_plus4_o = id_pc_q + 32'd4;
  assign if_instr_o    = id_valid_q ? id_instr_q : NOP_INSTR;
  assign if_valid_o    = id_valid_q;
  assign halted_o      = state_q == HALT;
  assign misalign_o    = mis_q;
  assign fetch_count_o = count_q;
  // next-state and next-register values; redirect beats stall beats normal fetch
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    mis_d      = mis_q;
    count_d    = count_q;
    case (state_q)
      BOOT: begin
        state_d    = RUN;
        id_valid_d = 1'b0;
      end
      RUN: begin
        if (redirect_i) begin
          pc_d       = target;
          id_valid_d = 1'b0;
          mis_d      = mis_q | target_mis;
          state_d    = target_in ? RUN : HALT;
        end else if (stall_i) begin
          id_valid_d = flush_i ? 1'b0 : id_valid_q;
        end else if (in_range) begin
          pc_d       = pc_q + 32'd4;
          id_valid_d = !flush_i;
          id_pc_d    = flush_i ? id_pc_q : pc_q;
          id_instr_d = flush_i ? id_instr_q : imem_rdata_i;
          count_d    = flush_i ? count_q : count_q + 32'd1;
        end else begin
          id_valid_d = 1'b0;
          state_d    = HALT;
        end
      end
      HALT: begin
        id_valid_d = 1'b0;
        mis_d      = mis_q | (redirect_i & target_mis);
        pc_d       = (redirect_i && target_in) ? target : pc_q;
        state_d    = (redirect_i && target_in) ? RUN : HALT;
      end
      default: state_d = BOOT;
    endcase
  end
  // state and pipeline registers, cleared asynchronously
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      id_pc_q    <= 32'd0;
      id_instr_q <= NOP_INSTR;
      id_valid_q <= 1'b0;
      mis_q      <= 1'b0;
      count_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
      mis_q      <= mis_d;
      count_q    <= count_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for the fetch stage
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, flush = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] imem_addr, imem_rdata, if_pc, if_pc_plus4, if_instr, fetch_count;
  logic        if_valid, halted, misalign;
  int          checks = 0, errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] pc;
    logic        valid;
    logic        halted;
    logic        mis;
    logic [31:0] cnt;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a == 32'd0 ? 32'h0051_8193 : a == 32'd4 ? 32'h00a2_0213 : (32'hA000_0000 | a);
  endfunction

  assign imem_rdata = imem_addr < 32'd384 ? word(imem_addr) : 32'hDEAD_BEEF;

  fetch_unit dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_addr_o(imem_addr), .imem_rdata_i(imem_rdata),
    .if_pc_o(if_pc), .if_pc_plus4_o(if_pc_plus4), .if_instr_o(if_instr),
    .if_valid_o(if_valid), .halted_o(halted), .misalign_o(misalign),
    .fetch_count_o(fetch_count)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, req, $time);
    end
  endtask

  task automatic push(input logic [31:0] addr, pc, input logic v, h, m, input logic [31:0] cnt);
    exp_t x;
    x.addr = addr; x.pc = pc; x.valid = v; x.halted = h; x.mis = m; x.cnt = cnt;
    sb.push_back(x);
  endtask

  // one clock of stimulus; expected outputs after the edge go to the scoreboard
  task automatic step(input logic rd, input logic [31:0] rpc, input logic st, fl,
                      input logic [31:0] addr, pc, input logic v, h, m, input logic [31:0] cnt);
    redirect = rd; redirect_pc = rpc; stall = st; flush = fl;
    @(posedge clk);
    #1 push(addr, pc, v, h, m, cnt);
    @(negedge clk);
  endtask

  // monitor: compare DUT outputs against the oldest expectation away from the clock edge
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("imem_addr", imem_addr, e.addr);
      chk("if_pc", if_pc, e.pc);
      chk("if_pc_plus4", if_pc_plus4, e.pc + 32'd4);
      chk("if_instr", if_instr, e.valid ? word(e.pc) : 32'h0000_0013);
      chk("if_valid", {31'd0, if_valid}, {31'd0, e.valid});
      chk("halted", {31'd0, halted}, {31'd0, e.halted});
      chk("misalign", {31'd0, misalign}, {31'd0, e.mis});
      chk("fetch_count", fetch_count, e.cnt);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    #1 push(0, 0, 0, 0, 0, 0);
    @(negedge clk) rst = 1'b0;
    step(0, 0, 0, 0,  0,     0, 0, 0, 0, 0);
    step(0, 0, 0, 0,  4,     0, 1, 0, 0, 1);
    step(0, 0, 0, 0,  8,     4, 1, 0, 0, 2);
    step(0, 0, 0, 0,  12,    8, 1, 0, 0, 3);
    step(0, 0, 1, 0,  12,    8, 1, 0, 0, 3);
    step(0, 0, 1, 0,  12,    8, 1, 0, 0, 3);
    step(0, 0, 1, 1,  12,    8, 0, 0, 0, 3);
    step(0, 0, 0, 0,  16,   12, 1, 0, 0, 4);
    step(1, 32'h70, 0, 0, 32'h70, 12, 0, 0, 0, 4);
    step(0, 0, 0, 0,  32'h74, 32'h70, 1, 0, 0, 5);
    step(0, 0, 0, 1,  32'h78, 32'h70, 0, 0, 0, 5);
    step(0, 0, 0, 0,  32'h7C, 32'h78, 1, 0, 0, 6);
    step(1, 32'h46, 0, 0, 32'h44, 32'h78, 0, 0, 1, 6);
    step(0, 0, 0, 0,  32'h48, 32'h44, 1, 0, 1, 7);
    step(1, 32'h17C, 1, 0, 32'h17C, 32'h44, 0, 0, 1, 7);
    step(0, 0, 0, 0,  384,  380, 1, 0, 1, 8);
    step(0, 0, 0, 0,  384,  380, 0, 1, 1, 8);
    step(0, 0, 1, 1,  384,  380, 0, 1, 1, 8);
    step(1, 32'h1000, 0, 0, 384, 380, 0, 1, 1, 8);
    step(1, 0, 0, 0,  0,    380, 0, 0, 1, 8);
    step(0, 0, 0, 0,  4,      0, 1, 0, 1, 9);
    step(0, 0, 0, 0,  8,      4, 1, 0, 1, 10);
    step(1, 32'h1000, 0, 0, 32'h1000, 4, 0, 1, 1, 10);
    step(1, 0, 0, 0,  0,      4, 0, 0, 1, 10);
    for (int i = 0; i < 96; i++)
      step(0, 0, 0, 0, 32'(4 * i + 4), 32'(4 * i), 1, 0, 1, 32'(11 + i));
    step(0, 0, 0, 0,  384,  380, 0, 1, 1, 106);
    step(1, 32'h28, 0, 0, 32'h28, 380, 0, 0, 1, 106);
    step(0, 0, 1, 0,  32'h28, 380, 0, 0, 1, 106);
    stall = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 push(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0,  4, 0, 1, 0, 0, 1);
    redirect = 1'b0; stall = 1'b0; flush = 1'b0;
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the single-issue RISC-V core. It owns the program counter, drives the word address into the combinational instruction memory, and registers the returned word into the IF/ID pipeline register for decode. It accepts redirects from execute (branches, JAL, JALR), stall and flush requests from hazard control, and halts when the PC leaves the instruction memory.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset (word aligned)
- MEM_SIZE, 96, instruction-memory depth in 32-bit words; valid fetch range is 0 .. MEM_SIZE*4-1
- NOP_INSTR, 32'h0000_0013, bubble word (addi x0,x0,0) presented when IF/ID is invalid

- clk_i  in  1  core clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- stall_i  in  1  hold PC and IF/ID contents
- flush_i  in  1  invalidate IF/ID at next edge
- redirect_i  in  1  load redirect_pc_i as next PC
- redirect_pc_i  in  32  branch/jump target from execute
- imem_addr_o  out  32  byte address to instruction memory
- imem_rdata_i  in  32  instruction word returned combinationally
- if_pc_o  out  32  PC of the instruction in IF/ID
- if_pc_plus4_o  out  32  if_pc_o + 4 (link value for JAL/JALR)
- if_instr_o  out  32  instruction in IF/ID, NOP_INSTR when invalid
- if_valid_o  out  1  IF/ID holds a real instruction
- halted_o  out  1  fetch is in HALT
- misalign_o  out  1  sticky: a redirect target had bits[1:0] != 0
- fetch_count_o  out  32  number of instructions captured into IF/ID

## Operation
- Registers: pc_q, IF/ID {pc, instr, valid}, state, misalign flag, fetch counter.
- imem_addr_o = pc_q (combinational); in-range = pc_q < MEM_SIZE*4.
- FSM states: BOOT, RUN, HALT.
  - BOOT: entered on reset; one cycle; no capture; next = RUN.
  - RUN: per edge, priority redirect_i > stall_i > normal.
    - redirect_i: pc_q <= {redirect_pc_i[31:2],2'b00}; IF/ID valid <= 0; if redirect_pc_i[1:0]!=0 set misalign flag; if aligned target >= MEM_SIZE*4, next = HALT.
    - else stall_i: pc_q and IF/ID held; flush_i still clears IF/ID valid.
    - else if pc_q in range: IF/ID <= {pc_q, imem_rdata_i, 1}; pc_q <= pc_q+4; counter += 1 (wraps at 2^32).
    - else (pc_q out of range): IF/ID valid <= 0; next = HALT; pc_q held.
    - flush_i without redirect and without stall: capture suppressed (valid <= 0), PC still advances.
  - HALT: halted_o=1, IF/ID valid=0, pc_q held; stall_i/flush_i ignored; redirect_i to an in-range target loads PC and returns to RUN; out-of-range redirect stays in HALT.
- if_instr_o = valid ? stored instr : NOP_INSTR.
- Arithmetic: pc+4 modulo 2^32; if_pc_plus4_o computed from IF/ID pc, modulo 2^32.

## Timing
- Reset values: pc_q=RESET_PC, imem_addr_o=RESET_PC, if_pc_o=0, if_pc_plus4_o=4, if_instr_o=NOP_INSTR, if_valid_o=0, halted_o=0, misalign_o=0, fetch_count_o=0, state=BOOT.
- Reset asynchronous: asserting rst_i mid-operation clears all state immediately, regardless of stall/redirect.
- Fetch latency: instruction at address A appears on if_instr_o the edge after pc_q = A (1 cycle).
- First valid instruction: 2nd rising edge after rst_i deasserts (BOOT + one capture).
- Redirect penalty: 1 bubble; target instruction valid 2 edges after the redirect edge.
- Stall: outputs hold bit-exact for every stalled cycle; the fetch counter does not increment.
- Stall+flush same cycle: valid cleared, PC held. Redirect+stall: redirect wins.
- misalign_o is cleared only by reset.

## Test plan
- Reset then free run with the standard program (word0=32'h00518193, word1=32'h00a20213): edge 2 -> if_pc_o=0, if_instr_o=32'h00518193, if_valid_o=1; edge 3 -> if_pc_o=4, if_instr_o=32'h00a20213, fetch_count_o=2.
- redirect_i=1, redirect_pc_i=32'h70 for one cycle during RUN -> next edge if_valid_o=0 and if_instr_o=32'h00000013; following edge if_pc_o=32'h70, if_pc_plus4_o=32'h74, if_valid_o=1.
- stall_i high 3 cycles with if_pc_o=8 -> if_pc_o, if_instr_o, fetch_count_o unchanged for 3 cycles; stall+flush in the last cycle -> if_valid_o=0, next capture is pc 12.
- Run sequentially to pc_q=MEM_SIZE*4=384 -> last valid if_pc_o=380, then if_valid_o=0, halted_o=1; redirect to 0 -> halted_o=0, 2 edges later if_pc_o=0 valid.
- redirect_pc_i=32'h0000_0046 -> misalign_o=1 (sticky), subsequent capture has if_pc_o=32'h44; redirect to 32'h1000 -> HALT.
- Assert rst_i asynchronously mid-stall with pc_q=40 -> all outputs return to reset values before the next clock edge.
